// File: rtl/wb_result_ctrl.sv
// Result write-back controller: collects result words into the result RAM, then drains them to the host.
// Optional XOR checksum of collected words is built only when WB_CHECKSUM_EN is defined.
module wb_result_ctrl #(
   parameter int DATA_W    = 128,
   parameter int ADDR_W    = 6,
   parameter int MEM_DEPTH = 32
) (
   input  logic              wb_clk,
   input  logic              wb_reset,
   input  logic [2:0]        wb_cmd,
   input  logic [ADDR_W-1:0] wb_length,
   input  logic              pu_res_valid,
   input  logic [DATA_W-1:0] pu_res_data,
   output logic              pu_res_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] host_data_out,
   output logic              host_valid,
   input  logic              host_ready,
   output logic              wb_full,
   output logic              wb_done,
   output logic [DATA_W-1:0] wb_checksum
);

   // state      | meaning
   // S_IDLE     | waiting for start collect
   // S_COLLECT  | accepting result words, writing RAM
   // S_FULL     | batch held, waiting for drain command
   // S_RD_ISSUE | read address on the RAM bus
   // S_RD_WAIT  | RAM read data becomes valid
   // S_RD_OUT   | word presented to host until accepted

   localparam int CNT_W = ADDR_W + 1;
   localparam logic [2:0]       CMD_START = 3'b100;
   localparam logic [2:0]       CMD_DRAIN = 3'b010;
   localparam logic [2:0]       CMD_ABORT = 3'b000;
   localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(MEM_DEPTH);
   localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_COLLECT,
      S_FULL,
      S_RD_ISSUE,
      S_RD_WAIT,
      S_RD_OUT
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] wr_cnt;
   logic [CNT_W-1:0] rd_cnt;
   logic [CNT_W-1:0] n_tgt;
   logic [CNT_W-1:0] len_p1;
   logic [CNT_W-1:0] wr_cnt_nxt;
   logic [CNT_W-1:0] rd_cnt_nxt;
   logic             cmd_start;
   logic             cmd_drain;
   logic             cmd_abort;
   logic             wr_acc;

   assign len_p1     = {1'b0, wb_length} + ONE_C;
   assign wr_cnt_nxt = wr_cnt + ONE_C;
   assign rd_cnt_nxt = rd_cnt + ONE_C;
   assign cmd_start  = (wb_cmd == CMD_START);
   assign cmd_drain  = (wb_cmd == CMD_DRAIN);
   assign cmd_abort  = (wb_cmd == CMD_ABORT) && (state != S_IDLE);

   assign pu_res_ready = (state == S_COLLECT) && (wr_cnt < n_tgt);
   // A word offered in the abort cycle completes the handshake but is dropped.
   assign wr_acc       = pu_res_valid && pu_res_ready && !cmd_abort;

   always_ff @(posedge wb_clk or negedge wb_reset) begin
      if (!wb_reset) begin
         state         <= S_IDLE;
         wr_cnt        <= '0;
         rd_cnt        <= '0;
         n_tgt         <= '0;
         mem_addr      <= '0;
         mem_we        <= 1'b0;
         mem_wdata     <= '0;
         host_data_out <= '0;
         host_valid    <= 1'b0;
         wb_full       <= 1'b0;
         wb_done       <= 1'b0;
      end else begin
         mem_we  <= 1'b0;
         wb_done <= 1'b0;
         if (cmd_abort) begin
            state      <= S_IDLE;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            n_tgt      <= '0;
            host_valid <= 1'b0;
            wb_full    <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (cmd_start) begin
                     n_tgt  <= (len_p1 > DEPTH_C) ? DEPTH_C : len_p1;
                     wr_cnt <= '0;
                     rd_cnt <= '0;
                     state  <= S_COLLECT;
                  end
               end
               S_COLLECT: begin
                  if (wr_acc) begin
                     mem_we    <= 1'b1;
                     mem_addr  <= wr_cnt[ADDR_W-1:0];
                     mem_wdata <= pu_res_data;
                     wr_cnt    <= wr_cnt_nxt;
                  end
                  if (cmd_drain) begin
                     n_tgt   <= wr_acc ? wr_cnt_nxt : wr_cnt;
                     wb_full <= 1'b1;
                     state   <= S_FULL;
                  end else if (wr_acc && (wr_cnt_nxt == n_tgt)) begin
                     wb_full <= 1'b1;
                     state   <= S_FULL;
                  end
               end
               S_FULL: begin
                  if (cmd_drain) begin
                     wb_full <= 1'b0;
                     rd_cnt  <= '0;
                     if (n_tgt == '0) begin
                        wb_done <= 1'b1;
                        state   <= S_IDLE;
                     end else begin
                        // Address goes out with the entry into RD_ISSUE so data is ready by RD_OUT.
                        mem_addr <= '0;
                        state    <= S_RD_ISSUE;
                     end
                  end
               end
               S_RD_ISSUE: begin
                  state <= S_RD_WAIT;
               end
               S_RD_WAIT: begin
                  host_data_out <= mem_rdata;
                  host_valid    <= 1'b1;
                  state         <= S_RD_OUT;
               end
               S_RD_OUT: begin
                  if (host_ready) begin
                     host_valid <= 1'b0;
                     rd_cnt     <= rd_cnt_nxt;
                     if (rd_cnt_nxt == n_tgt) begin
                        wb_done <= 1'b1;
                        state   <= S_IDLE;
                     end else begin
                        mem_addr <= rd_cnt_nxt[ADDR_W-1:0];
                        state    <= S_RD_ISSUE;
                     end
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

`ifdef WB_CHECKSUM_EN
   logic [DATA_W-1:0] csum;

   always_ff @(posedge wb_clk or negedge wb_reset) begin
      if (!wb_reset) begin
         csum <= '0;
      end else if (cmd_abort || ((state == S_IDLE) && cmd_start)) begin
         csum <= '0;
      end else if (wr_acc) begin
         csum <= csum ^ pu_res_data;
      end
   end

   assign wb_checksum = csum;
`else
   assign wb_checksum = '0;
`endif

endmodule

// File: tb/tb_wb_result_ctrl.sv
// Scoreboard bench for wb_result_ctrl: random batches checked against a queue-based model of the write/drain path.
module tb_wb_result_ctrl;

   localparam logic [2:0] CMD_START = 3'b100;
   localparam logic [2:0] CMD_DRAIN = 3'b010;
   localparam logic [2:0] CMD_ABORT = 3'b000;
   localparam logic [2:0] CMD_NOP   = 3'b111;
`ifdef WB_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   logic         wb_clk;
   logic         wb_reset;
   logic [2:0]   wb_cmd;
   logic [5:0]   wb_length;
   logic         pu_res_valid;
   logic [127:0] pu_res_data;
   logic         pu_res_ready;
   logic [5:0]   mem_addr;
   logic         mem_we;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata;
   logic [127:0] host_data_out;
   logic         host_valid;
   logic         host_ready;
   logic         wb_full;
   logic         wb_done;
   logic [127:0] wb_checksum;

   wb_result_ctrl dut (
      .wb_clk        (wb_clk),
      .wb_reset      (wb_reset),
      .wb_cmd        (wb_cmd),
      .wb_length     (wb_length),
      .pu_res_valid  (pu_res_valid),
      .pu_res_data   (pu_res_data),
      .pu_res_ready  (pu_res_ready),
      .mem_addr      (mem_addr),
      .mem_we        (mem_we),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata),
      .host_data_out (host_data_out),
      .host_valid    (host_valid),
      .host_ready    (host_ready),
      .wb_full       (wb_full),
      .wb_done       (wb_done),
      .wb_checksum   (wb_checksum)
   );

   initial begin
      wb_clk = 1'b0;
      forever #5 wb_clk = ~wb_clk;
   end

   // Result RAM, synchronous read.
   logic [127:0] ram [0:31];
   always @(posedge wb_clk) begin
      if (mem_we) ram[mem_addr[4:0]] <= mem_wdata;
      mem_rdata <= ram[mem_addr[4:0]];
   end

   int cyc = 0;
   always @(posedge wb_clk) cyc <= cyc + 1;

   typedef struct {
      logic [5:0]   addr;
      logic [127:0] data;
   } wr_t;

   wr_t          wq[$];
   logic [127:0] hq[$];
   logic [127:0] model_mem [0:31];
   logic [127:0] m_csum;
   int           m_n;
   int           m_cnt;
   int           checks = 0;
   int           errors = 0;
   int           done_cnt = 0;
   int           words_out = 0;
   int           n_writes = 0;

   task automatic fail(string name);
      checks++;
      errors++;
      $display("FAIL %s (unexpected event)", name);
   endtask

   task automatic chk128(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic chk1(string name, logic act, logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0b required=%0b", name, act, exp);
      end
   endtask

   task automatic chki(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic logic [127:0] exp_csum();
      return CSUM_EN ? m_csum : 128'h0;
   endfunction

   // Monitor: pops the scoreboard whenever the DUT writes RAM or hands a word to the host.
   initial begin
      logic         p_valid;
      logic         p_ready;
      logic [2:0]   p_cmd;
      logic [127:0] p_data;
      logic [5:0]   p_addr;
      wr_t          w;
      p_valid = 1'b0;
      p_ready = 1'b0;
      p_cmd   = CMD_NOP;
      p_data  = '0;
      p_addr  = '0;
      forever begin
         @(negedge wb_clk);
         if (wb_reset) begin
            if (mem_we) begin
               n_writes++;
               if (wq.size() == 0) fail("unexp_write");
               else begin
                  w = wq.pop_front();
                  chki("wr_addr", int'(mem_addr), int'(w.addr));
                  chk128("wr_data", mem_wdata, w.data);
               end
            end
            if (host_valid && host_ready) begin
               words_out++;
               if (hq.size() == 0) fail("unexp_host");
               else chk128("host_data", host_data_out, hq.pop_front());
            end
            if (p_valid && !p_ready && (p_cmd != CMD_ABORT)) begin
               chk1("bp_valid", host_valid, 1'b1);
               chk128("bp_data", host_data_out, p_data);
               chki("bp_addr", int'(mem_addr), int'(p_addr));
            end
            if (wb_done) done_cnt++;
            p_valid = host_valid;
            p_ready = host_ready;
            p_cmd   = wb_cmd;
            p_data  = host_data_out;
            p_addr  = mem_addr;
         end else begin
            p_valid = 1'b0;
         end
      end
   end

   task automatic chk_all_zero(string tag);
      chk1({tag, "_ready"}, pu_res_ready, 1'b0);
      chki({tag, "_addr"}, int'(mem_addr), 0);
      chk1({tag, "_we"}, mem_we, 1'b0);
      chk128({tag, "_wdata"}, mem_wdata, 128'h0);
      chk128({tag, "_hdata"}, host_data_out, 128'h0);
      chk1({tag, "_hvalid"}, host_valid, 1'b0);
      chk1({tag, "_full"}, wb_full, 1'b0);
      chk1({tag, "_done"}, wb_done, 1'b0);
      chk128({tag, "_csum"}, wb_checksum, 128'h0);
   endtask

   // action: 0 none, 1 early end, 2 abort, 3 async reset; applied once m_cnt reaches stop_at.
   task automatic collect(int len, int stop_at, int action, bit dense, bit fixed);
      bit           acc;
      bit           prev_acc;
      bit           stop;
      logic [127:0] d;
      wr_t          w;
      wb_cmd    = CMD_START;
      wb_length = len[5:0];
      @(posedge wb_clk); #1;
      wb_cmd   = CMD_NOP;
      m_n      = (len + 1 > 32) ? 32 : len + 1;
      m_cnt    = 0;
      m_csum   = '0;
      prev_acc = 1'b0;
      for (int i = 0; i < 400 && m_cnt < m_n; i++) begin
         stop = (action != 0) && (m_cnt >= stop_at);
         if (stop && action == 3) begin
            wb_reset = 1'b0;
            #1;
            chk_all_zero("rst_mid");
            wq.delete();
            m_n    = 0;
            m_cnt  = 0;
            m_csum = '0;
            @(negedge wb_clk);
            wb_reset = 1'b1;
            @(posedge wb_clk); #1;
            return;
         end
         d = fixed ? (128'h1 << m_cnt) : rand128();
         pu_res_valid = dense || ($urandom_range(0, 3) != 0);
         if (stop && action == 2) pu_res_valid = 1'b1;
         if (stop && action == 1 && stop_at == 0) pu_res_valid = 1'b0;
         pu_res_data = d;
         if (stop) wb_cmd = (action == 1) ? CMD_DRAIN : CMD_ABORT;
         @(negedge wb_clk);
         chk1("ready", pu_res_ready, m_cnt < m_n);
         chk1("we_lat", mem_we, prev_acc);
         acc = pu_res_valid && (m_cnt < m_n) && !(stop && action == 2);
         if (acc) begin
            w.addr = m_cnt[5:0];
            w.data = d;
            wq.push_back(w);
            model_mem[m_cnt] = d;
            m_csum = m_csum ^ d;
            m_cnt++;
         end
         prev_acc = acc;
         @(posedge wb_clk); #1;
         pu_res_valid = 1'b0;
         wb_cmd       = CMD_NOP;
         if (stop && action == 1) begin
            m_n = m_cnt;
            break;
         end
         if (stop && action == 2) begin
            @(negedge wb_clk);
            chk1("abort_ready", pu_res_ready, 1'b0);
            chk1("abort_we", mem_we, 1'b0);
            chk1("abort_full", wb_full, 1'b0);
            chk128("abort_csum", wb_checksum, 128'h0);
            m_n   = 0;
            m_cnt = 0;
            @(posedge wb_clk); #1;
            return;
         end
      end
      @(negedge wb_clk);
      chk1("full_set", wb_full, 1'b1);
      chk1("ready_full", pu_res_ready, 1'b0);
      chk1("we_last", mem_we, prev_acc);
      chk128("csum", wb_checksum, exp_csum());
      @(posedge wb_clk); #1;
   endtask

   // mode: 0 host always ready, 1 random host_ready, 2 hold word 1 for 5 cycles.
   task automatic drain(int mode);
      int done0;
      int out0;
      int first;
      int hold;
      int c0;
      done0 = done_cnt;
      out0  = words_out;
      first = -1;
      hold  = 0;
      wb_cmd = CMD_START;
      @(posedge wb_clk); #1;
      wb_cmd = 3'b001;
      @(negedge wb_clk);
      chk1("full_ignores_cmd", wb_full, 1'b1);
      @(posedge wb_clk); #1;
      for (int i = 0; i < m_n; i++) hq.push_back(model_mem[i]);
      wb_cmd     = CMD_DRAIN;
      host_ready = 1'b1;
      c0 = cyc;
      for (int k = 0; k < 800 && done_cnt == done0; k++) begin
         @(posedge wb_clk); #1;
         wb_cmd = CMD_NOP;
         if (mode == 1) host_ready = ($urandom_range(0, 1) == 1);
         else if (mode == 2 && host_valid && (words_out - out0) == 1 && hold < 5) begin
            host_ready = 1'b0;
            hold++;
         end else host_ready = 1'b1;
         @(negedge wb_clk);
         if (k == 0) chk1("full_drop", wb_full, 1'b0);
         if (host_valid && first < 0) first = cyc - c0;
      end
      repeat (2) @(posedge wb_clk);
      #1;
      host_ready = 1'b1;
      chki("done_pulses", done_cnt - done0, 1);
      chki("drain_words", words_out - out0, m_n);
      chki("drain_left", hq.size(), 0);
      chk1("hvalid_after", host_valid, 1'b0);
      chk128("csum_hold", wb_checksum, exp_csum());
      if (mode == 0 && m_n > 0) chki("drain_lat", first, 3);
      if (mode == 2) chki("bp_hold_cycles", hold, 5);
   endtask

   task automatic abort_drain();
      int k;
      int done0;
      wb_cmd     = CMD_DRAIN;
      host_ready = 1'b0;
      @(posedge wb_clk); #1;
      wb_cmd = CMD_NOP;
      k = 0;
      while (!host_valid && k < 10) begin
         @(posedge wb_clk); #1;
         k++;
      end
      chk1("rdout_reached", host_valid, 1'b1);
      wb_cmd = CMD_ABORT;
      @(posedge wb_clk); #1;
      wb_cmd = CMD_NOP;
      chk1("abort_hvalid", host_valid, 1'b0);
      chk1("abort_full2", wb_full, 1'b0);
      chk1("abort_we2", mem_we, 1'b0);
      chk128("abort_csum2", wb_checksum, 128'h0);
      done0  = done_cnt;
      wb_cmd = CMD_DRAIN;
      @(posedge wb_clk); #1;
      wb_cmd = CMD_NOP;
      repeat (4) @(posedge wb_clk);
      #1;
      chki("idle_ignores_drain", done_cnt - done0, 0);
      chk1("idle_no_hvalid", host_valid, 1'b0);
      host_ready = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0;
      wb_reset     = 1'b0;
      wb_cmd       = CMD_NOP;
      wb_length    = '0;
      pu_res_valid = 1'b0;
      pu_res_data  = '0;
      host_ready   = 1'b1;
      repeat (3) @(posedge wb_clk);
      #1;
      chk_all_zero("reset");
      @(negedge wb_clk);
      wb_reset = 1'b1;
      @(posedge wb_clk); #1;

      collect(3, 0, 0, 1'b1, 1'b0);
      drain(0);
      collect(3, 0, 0, 1'b1, 1'b0);
      drain(2);

      w0 = n_writes;
      collect(63, 0, 0, 1'b0, 1'b0);
      chki("clamp_writes", n_writes - w0, 32);
      drain(1);

      collect(7, 2, 1, 1'b0, 1'b0);
      drain(0);
      collect(7, 0, 1, 1'b0, 1'b0);
      chki("zero_n", m_n, 0);
      drain(0);

      collect(2, 0, 0, 1'b1, 1'b1);
      chk128("csum_0x7", wb_checksum, CSUM_EN ? 128'h7 : 128'h0);
      drain(0);

      collect(9, 3, 2, 1'b0, 1'b0);
      collect(4, 0, 0, 1'b0, 1'b0);
      abort_drain();
      collect(9, 4, 3, 1'b1, 1'b0);

      for (int b = 0; b < 4; b++) begin
         collect(int'($urandom_range(0, 40)), 0, 0, 1'b0, 1'b0);
         drain(1);
      end
      collect(20, int'($urandom_range(1, 10)), 1, 1'b0, 1'b0);
      drain(1);

      repeat (3) @(posedge wb_clk);
      #1;
      chki("wq_left", wq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_result_ctrl.md
# wb_result_ctrl

Result write-back controller, the return path of the memory controller. It accepts result words from the processing units over a valid/ready handshake and writes them into the result RAM. On command from core control it reads them back and presents them, one word at a time, to the host output port. The result RAM is instantiated at top level; this block only drives its address, write-enable and write-data, and samples its read data.

## Interface
- DATA_W, 128, result word width
- ADDR_W, 6, RAM address width
- MEM_DEPTH, 32, usable RAM words; hard cap on words per batch
---
- wb_clk  in  1  clock, rising edge
- wb_reset  in  1  asynchronous, active-low reset
- wb_cmd  in  3  core-control command: 100 = start collect, 010 = start drain / end collect early, 000 = abort; all other codes are ignored
- wb_length  in  ADDR_W  batch length; words expected = min(wb_length+1, MEM_DEPTH), sampled on start collect
- pu_res_valid  in  1  result word valid
- pu_res_data  in  DATA_W  result word
- pu_res_ready  out  1  block accepts a result word
- mem_addr  out  ADDR_W  RAM address (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_wdata  out  DATA_W  RAM write data (registered)
- mem_rdata  in  DATA_W  RAM read data; synchronous RAM, valid one cycle after the address edge
- host_data_out  out  DATA_W  drained word
- host_valid  out  1  host_data_out valid
- host_ready  in  1  host accepts the word
- wb_full  out  1  level: batch collected, waiting for drain
- wb_done  out  1  one-cycle pulse: drain complete
- wb_checksum  out  DATA_W  XOR of the collected words (see Configuration)

## Operation
- States: IDLE, COLLECT, FULL, RD_ISSUE, RD_WAIT, RD_OUT.
- Reset (async, wb_reset=0):
  - State returns to IDLE.
  - Every output is 0: pu_res_ready, mem_addr, mem_we, mem_wdata, host_data_out, host_valid, wb_full, wb_done, wb_checksum.
  - Internal counters wr_cnt, rd_cnt and target N are cleared.
- IDLE:
  - On wb_cmd=100: latch N = min(wb_length+1, MEM_DEPTH), clear wr_cnt and checksum, go to COLLECT.
- COLLECT:
  - pu_res_ready = (state==COLLECT) && (wr_cnt<N). It is combinational from registers only and never depends on pu_res_valid.
  - On valid&&ready, the next cycle shows mem_we=1, mem_addr=wr_cnt, mem_wdata=pu_res_data. wr_cnt then increments.
  - If no word is accepted, mem_we=0 the next cycle.
  - After the N-th accept, go to FULL.
  - wb_cmd=010 ends collection early with N := wr_cnt. Any word accepted in that same cycle is still written and counted.
- FULL:
  - wb_full=1.
  - On wb_cmd=010, go to RD_ISSUE with rd_cnt=0.
- Zero-word drain: a drain request with N=0 (early end before any word) produces a wb_done pulse and returns to IDLE. No host_valid is issued.
- Drain loop, one word per pass:
  - RD_ISSUE: mem_addr ← rd_cnt.
  - RD_WAIT: the RAM samples the address.
  - RD_OUT: host_data_out ← mem_rdata, host_valid=1, held stable until host_ready=1.
  - On valid&&ready: rd_cnt increments and host_valid drops the next cycle. If rd_cnt+1==N, pulse wb_done and go to IDLE; otherwise go to RD_ISSUE.
- wb_cmd=000 in any non-IDLE state:
  - Abort to IDLE next cycle.
  - pu_res_ready, host_valid, mem_we and wb_full drop to 0.
  - Counters clear; RAM contents are left as they are.
  - Abort wins over any simultaneous handshake. A word presented in the abort cycle is not written.
- wb_cmd=100 outside IDLE is ignored.
- wb_cmd=010 outside COLLECT/FULL is ignored.

## Timing
- Write latency: accept edge to mem_we=1 is 1 cycle. Back-to-back accepts give one write per cycle.
- Drain latency: FULL+cmd to the first host_valid is 3 edges (RD_ISSUE, RD_WAIT, RD_OUT).
- Drain throughput: at most 1 word per 3 cycles.
- wb_done is high for exactly one cycle, coincident with the state entering IDLE.
- wb_full drops in the cycle RD_ISSUE is entered.
- Counters are ADDR_W+1 bits wide, so N=MEM_DEPTH (32) does not wrap. Addresses are 0..N-1.

## Configuration
- WB_CHECKSUM_EN defined:
  - wb_checksum accumulates the XOR of every word accepted in COLLECT.
  - It is cleared on start collect and on abort, and held stable through FULL and the drain.
- Not defined: the accumulator is not built and wb_checksum is tied to 0. The port is always present.

## Test plan
- Full batch: wb_length=3, 4 words A0..A3 with valid held high. Required: 4 consecutive mem_we pulses at addr 0..3, then wb_full=1 and pu_res_ready=0.
- Drain: after the full batch, cmd=010 with host_ready=1. Required: host_data_out A0..A3 in order, first host_valid 3 cycles after the command, then a single wb_done pulse.
- Backpressure: hold host_ready=0 for 5 cycles on word 1. Required: host_valid and host_data_out stay stable, with no RAM address change.
- Length clamp: wb_length=63. Required: exactly 32 writes at addr 0..31, then FULL.
- Early end and zero drain:
  - cmd=010 after 2 of 8 words. Required: the drain emits exactly 2 words.
  - cmd=010 then cmd=010 with 0 words. Required: wb_done with no host_valid.
- Abort and reset:
  - cmd=000 in RD_OUT. Required: host_valid=0 next cycle, state IDLE.
  - wb_reset low mid-COLLECT. Required: all outputs 0 immediately.
  - With WB_CHECKSUM_EN, words 0x1,0x2,0x4. Required: checksum 0x7.
